// File: rtl/stack_game_ctrl_if.sv
// Signal bundle between the input conditioning / clock divider side and the
// burger-stacking game sequencer; the draw block reads the sequencer outputs.
interface stack_game_ctrl_if;
  logic        tick;
  logic        btn_l;
  logic        btn_r;
  logic        start;
  logic [9:0]  pos_x;
  logic [31:0] colors;
  logic [9:0]  item_x;
  logic [9:0]  item_y;
  logic [1:0]  item_color;
  logic        item_valid;
  logic [3:0]  height;
  logic [1:0]  lives;
  logic        game_over;
  logic        win;

  modport master (
    output tick, btn_l, btn_r, start,
    input  pos_x, colors, item_x, item_y, item_color, item_valid,
           height, lives, game_over, win
  );

  modport slave (
    input  tick, btn_l, btn_r, start,
    output pos_x, colors, item_x, item_y, item_color, item_valid,
           height, lives, game_over, win
  );
endinterface

// File: rtl/stack_game_ctrl.sv
// Burger-stacking game sequencer: spawns one falling item at a time, moves the
// player stack on frame ticks, judges catch/miss and tracks height and lives.
module stack_game_ctrl #(
  parameter int unsigned X_MIN        = 0,
  parameter int unsigned X_MAX        = 540,
  parameter int unsigned WIDTH        = 100,
  parameter int unsigned P_Y          = 400,
  parameter int unsigned HEIGHT_RATIO = 20,
  parameter int unsigned MOVE_STEP    = 4,
  parameter int unsigned FALL_STEP    = 4,
  parameter int unsigned LIVES        = 3,
  parameter logic [7:0]  SEED         = 8'hA5
) (
  input logic             clk,
  input logic             rst,
  stack_game_ctrl_if.slave bus
);

  localparam logic [9:0]  P_XMIN  = 10'(X_MIN);
  localparam logic [9:0]  P_XMAX  = 10'(X_MAX);
  localparam logic [9:0]  P_XMID  = 10'((X_MIN + X_MAX) / 2);
  localparam logic [9:0]  P_PY    = 10'(P_Y);
  localparam logic [9:0]  P_HR    = 10'(HEIGHT_RATIO);
  localparam logic [9:0]  P_MS    = 10'(MOVE_STEP);
  localparam logic [9:0]  P_FS    = 10'(FALL_STEP);
  localparam logic [10:0] P_W     = 11'(WIDTH);
  localparam logic [1:0]  P_LIVES = 2'(LIVES);

  typedef enum logic [2:0] {S_IDLE, S_SPAWN, S_FALL, S_JUDGE, S_OVER} state_t;

  state_t      r_state, w_state_nxt;

  logic [7:0]  r_lfsr;
  logic        r_start_d;
  logic [9:0]  r_pos_x,      w_pos_x_nxt;
  logic [31:0] r_colors,     w_colors_nxt;
  logic [9:0]  r_item_x,     w_item_x_nxt;
  logic [9:0]  r_item_y,     w_item_y_nxt;
  logic [1:0]  r_item_color, w_item_color_nxt;
  logic        r_item_valid, w_item_valid_nxt;
  logic [3:0]  r_height,     w_height_nxt;
  logic [1:0]  r_lives,      w_lives_nxt;
  logic        r_game_over,  w_game_over_nxt;
  logic        r_win,        w_win_nxt;

  logic        w_start_rise;
  logic        w_lfsr_fb;
  logic [9:0]  w_land_y;
  logic [9:0]  w_fall_y;
  logic        w_landing;
  logic        w_catch;
  logic [4:0]  w_h_inc;

  assign w_start_rise = bus.start & ~r_start_d;
  assign w_lfsr_fb    = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];
  assign w_land_y     = P_PY - (10'(r_height) + 10'd1) * P_HR;
  assign w_fall_y     = r_item_y + P_FS;
  assign w_landing    = (w_fall_y >= w_land_y);
  // Overlap test widened to 11 bits so x + WIDTH cannot wrap.
  assign w_catch      = ({1'b0, r_item_x} < {1'b0, r_pos_x} + P_W) &&
                        ({1'b0, r_pos_x} < {1'b0, r_item_x} + P_W);
  assign w_h_inc      = {1'b0, r_height} + 5'd1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_start_rise) w_state_nxt = S_SPAWN;
      S_SPAWN: w_state_nxt = S_FALL;
      S_FALL:  if (bus.tick && w_landing) w_state_nxt = S_JUDGE;
      S_JUDGE: begin
        if (w_catch) w_state_nxt = (w_h_inc == 5'd15) ? S_OVER : S_SPAWN;
        else         w_state_nxt = (r_lives == 2'd1) ? S_OVER : S_SPAWN;
      end
      S_OVER:  if (w_start_rise) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_pos_x_nxt      = r_pos_x;
    w_colors_nxt     = r_colors;
    w_item_x_nxt     = r_item_x;
    w_item_y_nxt     = r_item_y;
    w_item_color_nxt = r_item_color;
    w_item_valid_nxt = r_item_valid;
    w_height_nxt     = r_height;
    w_lives_nxt      = r_lives;
    w_game_over_nxt  = r_game_over;
    w_win_nxt        = r_win;
    case (r_state)
      S_SPAWN: begin
        w_item_x_nxt     = {1'b0, r_lfsr, 1'b0};
        w_item_color_nxt = (r_lfsr[1:0] == 2'b00) ? 2'b01 : r_lfsr[1:0];
        w_item_y_nxt     = '0;
        w_item_valid_nxt = 1'b1;
      end
      S_FALL: if (bus.tick) begin
        if (bus.btn_l && !bus.btn_r)
          w_pos_x_nxt = (r_pos_x < P_XMIN + P_MS) ? P_XMIN : r_pos_x - P_MS;
        else if (bus.btn_r && !bus.btn_l)
          w_pos_x_nxt = (r_pos_x + P_MS > P_XMAX) ? P_XMAX : r_pos_x + P_MS;
        w_item_y_nxt = w_landing ? w_land_y : w_fall_y;
      end
      S_JUDGE: begin
        w_item_valid_nxt = 1'b0;
        if (w_catch) begin
          for (int unsigned i = 1; i < 16; i++)
            if (w_h_inc == 5'(i)) w_colors_nxt[2*i +: 2] = r_item_color;
          w_height_nxt = w_h_inc[3:0];
          if (w_h_inc == 5'd15) begin
            w_win_nxt       = 1'b1;
            w_game_over_nxt = 1'b1;
          end
        end else if (r_lives == 2'd1) begin
          w_lives_nxt     = '0;
          w_game_over_nxt = 1'b1;
        end else begin
          w_lives_nxt = r_lives - 2'd1;
        end
      end
      S_OVER: if (w_start_rise) begin
        w_pos_x_nxt      = P_XMID;
        w_colors_nxt     = '0;
        w_item_x_nxt     = '0;
        w_item_y_nxt     = '0;
        w_item_color_nxt = '0;
        w_item_valid_nxt = 1'b0;
        w_height_nxt     = '0;
        w_lives_nxt      = P_LIVES;
        w_game_over_nxt  = 1'b0;
        w_win_nxt        = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_lfsr       <= SEED;
      r_start_d    <= 1'b0;
      r_pos_x      <= P_XMID;
      r_colors     <= '0;
      r_item_x     <= '0;
      r_item_y     <= '0;
      r_item_color <= '0;
      r_item_valid <= 1'b0;
      r_height     <= '0;
      r_lives      <= P_LIVES;
      r_game_over  <= 1'b0;
      r_win        <= 1'b0;
    end else begin
      r_lfsr       <= {r_lfsr[6:0], w_lfsr_fb};
      r_start_d    <= bus.start;
      r_pos_x      <= w_pos_x_nxt;
      r_colors     <= w_colors_nxt;
      r_item_x     <= w_item_x_nxt;
      r_item_y     <= w_item_y_nxt;
      r_item_color <= w_item_color_nxt;
      r_item_valid <= w_item_valid_nxt;
      r_height     <= w_height_nxt;
      r_lives      <= w_lives_nxt;
      r_game_over  <= w_game_over_nxt;
      r_win        <= w_win_nxt;
    end
  end

  assign bus.pos_x      = r_pos_x;
  assign bus.colors     = r_colors;
  assign bus.item_x     = r_item_x;
  assign bus.item_y     = r_item_y;
  assign bus.item_color = r_item_color;
  assign bus.item_valid = r_item_valid;
  assign bus.height     = r_height;
  assign bus.lives      = r_lives;
  assign bus.game_over  = r_game_over;
  assign bus.win        = r_win;

endmodule
